lcd_text_writer: RTL and testbench
==================================

# lcd_text_writer

Upstream command source for `lcd_controller`. It holds a 32-character frame buffer (2 lines × 16) written by the rest of the design. After power-up it issues the HD44780 init sequence, then repaints the whole display whenever the buffer has changed. Each byte goes to the controller through its `execute`/`is_ready` handshake, one transaction at a time.

## Interface
Parameters:
- `POWERUP_CYCLES`, default 750000: clock cycles to wait after reset before the first command (15 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (one clock domain, async active-low reset).
- `wr_en`  in  1  frame-buffer write strobe, one byte per cycle.
- `wr_addr`  in  5  buffer index; 0–15 are line 0, 16–31 are line 1.
- `wr_data`  in  8  character code.
- `lcd_ready`  in  1  from controller `is_ready`.
- `lcd_rs`  out  1  to controller `rs_in`; 0 is instruction, 1 is data.
- `lcd_rw`  out  1  to controller `rw_in`; always 0 (write).
- `lcd_data`  out  8  to controller `data_in`.
- `lcd_execute`  out  1  to controller `execute`.
- `init_done`  out  1  high once the init sequence has finished; sticky until reset.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset values:
  - `lcd_rs` = 0, `lcd_rw` = 0, `lcd_data` = 0x00, `lcd_execute` = 0.
  - `init_done` = 0, `busy` = 1.
  - All 32 buffer bytes = 0x20 (space).
  - `dirty` = 1, power-up counter = 0, state = POWERUP.
- Main states:
  - POWERUP: count to `POWERUP_CYCLES`−1, then go to INIT.
  - INIT: send, in order, 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment). After the fourth byte completes: set `init_done`, go to IDLE.
  - IDLE: if `dirty` = 1, clear `dirty` and go to LINE0.
  - LINE0: send instruction 0x80, then data bytes buf[0..15].
  - LINE1: send instruction 0xC0, then data bytes buf[16..31]; then go to IDLE.
- Byte transaction sub-FSM, run for every byte:
  - ISSUE: wait for `lcd_ready` = 1. In that cycle register `lcd_rs` and `lcd_data`, set `lcd_execute` = 1, go to ACCEPT.
  - ACCEPT: exactly one cycle. Clear `lcd_execute`; `lcd_ready` is ignored. Go to DONE.
  - DONE: wait for `lcd_ready` = 1. Then advance the byte index and return to ISSUE for the next byte, or exit.
- `lcd_rs` and `lcd_data` hold constant from ISSUE until DONE exits. The controller samples them late in its sequence.
- Buffer writes:
  - Accepted in every state, including during a repaint. A write sets `dirty` in the same edge.
  - A write during a repaint lands in the buffer. The repaint in progress may or may not show it, but `dirty` forces a second full repaint afterwards.
  - `wr_en` in the same cycle IDLE clears `dirty`: the set wins, so `dirty` stays 1.
- Buffer reads are synchronous. The byte index is 5 bits and wraps 31→0 only at the end of LINE1.
- Reset mid-operation: abort at once to the reset values. The buffer refills with spaces, and init runs again after POWERUP.

## Timing
- `lcd_execute` is never high for more than 1 consecutive cycle. It is asserted only in the cycle after `lcd_ready` was sampled 1 in ISSUE.
- Byte overhead in this block: ISSUE (≥1) + ACCEPT (1) + DONE (≥1) cycles, plus controller latency.
- First command is issued at cycle `POWERUP_CYCLES` + 1 after reset release, provided `lcd_ready` is 1.
- A full repaint is 34 transactions; a full init is 4.
- `busy` and `init_done` are registered and change on the edge that enters or leaves IDLE.

## Test plan
- **Init sequence.** Reset with `POWERUP_CYCLES`=8, controller model ready 10 cycles after each execute. Required: transactions 0x38, 0x0C, 0x01, 0x06 with rs=0; `init_done` rises; then 34 transactions follow (0x80, 16×0x20 with rs=1, 0xC0, 16×0x20); then `busy`=0.
- **Handshake.** Hold `lcd_ready`=0 for 50 cycles after POWERUP. Required: `lcd_execute` stays 0. Raise `lcd_ready`: required is one single-cycle execute pulse, with rs/data stable until `lcd_ready` returns to 1.
- **Single write.** Write 0x41 to addr 17 while IDLE. Required: one repaint where the byte after 0xC0 is 0x20 and the next is 0x41; afterwards `busy`=0.
- **Write during repaint.** Write 0x5A to addr 3 during the repaint of buf[10]. Required: a second full repaint follows immediately, with buf[3]=0x5A.
- **Same-cycle write and dirty clear.** Assert `wr_en` on the cycle IDLE clears `dirty`. Required: two repaints back-to-back.
- **Reset mid-repaint.** Assert `rst`=0 during LINE1. Required: all outputs at reset values asynchronously, `init_done`=0; after release, the init sequence repeats and a repaint of all spaces follows.

Source files
------------

// File: rtl/lcd_text_writer.sv
// Command source for an HD44780-style lcd_controller: runs the power-up init
// sequence, then repaints the 2x16 frame buffer whenever it has been written.
module lcd_text_writer #(
   parameter int POWERUP_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       lcd_ready,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       lcd_execute,
   output logic       init_done,
   output logic       busy
);

   localparam int CNT_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POWERUP_CYCLES - 1);

   typedef enum logic [2:0] {S_POWERUP, S_INIT, S_IDLE, S_LINE0, S_LINE1} state_t;
   typedef enum logic [1:0] {X_ISSUE, X_ACCEPT, X_DONE} xfer_t;

   state_t           state;
   xfer_t            xfer;
   logic [CNT_W-1:0] pu_cnt;
   logic [1:0]       init_step;
   logic             cmd_sent;
   logic             dirty;
   logic [4:0]       rd_idx;
   logic [4:0]       idx_nxt;
   logic [7:0]       rd_data;
   logic [7:0]       frame [32];
   logic             byte_done;
   logic [8:0]       next_byte;
   logic [7:0]       init_cmd;

   assign lcd_rw = 1'b0;

   // The read address looks one byte ahead so rd_data is already valid in the
   // first ISSUE cycle after the index advances.
   always_comb begin
      byte_done = (xfer == X_DONE) && lcd_ready;
      idx_nxt   = rd_idx;
      if (byte_done && cmd_sent && (state == S_LINE0 || state == S_LINE1))
         idx_nxt = rd_idx + 5'd1;
   end

   always_comb begin
      case (init_step)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = 8'h0C;
         2'd2:    init_cmd = 8'h01;
         default: init_cmd = 8'h06;
      endcase
      next_byte = 9'h000;
      case (state)
         S_INIT:  next_byte = {1'b0, init_cmd};
         S_LINE0: next_byte = cmd_sent ? {1'b1, rd_data} : 9'h080;
         S_LINE1: next_byte = cmd_sent ? {1'b1, rd_data} : 9'h0C0;
         default: next_byte = 9'h000;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++)
            frame[i] <= 8'h20;
         rd_data <= 8'h20;
      end else begin
         if (wr_en)
            frame[wr_addr] <= wr_data;
         rd_data <= frame[idx_nxt];
      end
   end

   // A write always re-arms dirty, even on the cycle IDLE consumes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_POWERUP;
         xfer        <= X_ISSUE;
         pu_cnt      <= '0;
         init_step   <= 2'd0;
         cmd_sent    <= 1'b0;
         dirty       <= 1'b1;
         rd_idx      <= 5'd0;
         lcd_rs      <= 1'b0;
         lcd_data    <= 8'h00;
         lcd_execute <= 1'b0;
         init_done   <= 1'b0;
         busy        <= 1'b1;
      end else begin
         if (wr_en)
            dirty <= 1'b1;
         else if (state == S_IDLE)
            dirty <= 1'b0;
         rd_idx <= idx_nxt;
         case (state)
            S_POWERUP: begin
               if (pu_cnt == CNT_LAST)
                  state <= S_INIT;
               else
                  pu_cnt <= pu_cnt + CNT_W'(1);
            end
            S_IDLE: begin
               if (dirty) begin
                  state    <= S_LINE0;
                  busy     <= 1'b1;
                  cmd_sent <= 1'b0;
                  xfer     <= X_ISSUE;
               end
            end
            default: begin
               case (xfer)
                  X_ISSUE: begin
                     if (lcd_ready) begin
                        {lcd_rs, lcd_data} <= next_byte;
                        lcd_execute        <= 1'b1;
                        xfer               <= X_ACCEPT;
                     end
                  end
                  X_ACCEPT: begin
                     lcd_execute <= 1'b0;
                     xfer        <= X_DONE;
                  end
                  default: begin
                     if (byte_done) begin
                        xfer <= X_ISSUE;
                        if (state == S_INIT) begin
                           if (init_step == 2'd3) begin
                              init_done <= 1'b1;
                              busy      <= 1'b0;
                              state     <= S_IDLE;
                           end else begin
                              init_step <= init_step + 2'd1;
                           end
                        end else if (!cmd_sent) begin
                           cmd_sent <= 1'b1;
                        end else if (state == S_LINE0 && rd_idx == 5'd15) begin
                           state    <= S_LINE1;
                           cmd_sent <= 1'b0;
                        end else if (state == S_LINE1 && rd_idx == 5'd31) begin
                           state    <= S_IDLE;
                           busy     <= 1'b0;
                           cmd_sent <= 1'b0;
                        end
                     end
                  end
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer with a simple lcd_controller model that
// raises ready 10 cycles after each execute.
module tb_lcd_text_writer;

   localparam int P = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = 5'd0;
   logic [7:0] wr_data = 8'h00;
   logic       lcd_ready;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;
   logic       lcd_execute;
   logic       init_done;
   logic       busy;

   logic       model_en = 1'b1;
   logic       model_rdy = 1'b1;
   logic       manual_rdy = 1'b0;

   int         checks = 0;
   int         failures = 0;
   int         exec_double = 0;
   int         unstable = 0;
   logic [8:0] txq [$];
   logic [7:0] model_buf [32];
   logic [8:0] init_exp [4] = '{9'h038, 9'h00C, 9'h001, 9'h006};

   assign lcd_ready = model_en ? model_rdy : manual_rdy;

   always #5 clk = ~clk;

   lcd_text_writer #(.POWERUP_CYCLES(P)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .lcd_ready(lcd_ready), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
      .lcd_execute(lcd_execute), .init_done(init_done), .busy(busy)
   );

   initial begin : ctrl_model
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst || !model_en) begin
            model_rdy = 1'b1;
            cnt = 0;
         end else if (lcd_execute) begin
            model_rdy = 1'b0;
            cnt = 10;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) model_rdy = 1'b1;
         end
      end
   end

   // Records every transaction and watches pulse width and rs/data stability.
   initial begin : monitor
      logic [8:0] held;
      bit hold;
      bit prev;
      hold = 0;
      prev = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            hold = 0;
            prev = 0;
         end else begin
            if (lcd_execute && prev) exec_double++;
            if (lcd_execute) begin
               txq.push_back({lcd_rs, lcd_data});
               held = {lcd_rs, lcd_data};
               hold = 1;
            end else if (hold) begin
               if ({lcd_rs, lcd_data} !== held) unstable++;
               if (lcd_ready) hold = 0;
            end
            prev = lcd_execute;
         end
      end
   end

   function automatic logic [8:0] repaint_byte(input int k);
      if (k == 0) return 9'h080;
      else if (k <= 16) return {1'b1, model_buf[k-1]};
      else if (k == 17) return 9'h0C0;
      else return {1'b1, model_buf[k-2]};
   endfunction

   task automatic wait_txns(input int n, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
      if (txq.size() >= n) ok = 1;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
      if (busy === 1'b0) ok = 1;
   endtask

   task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      model_buf[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({lcd_rs, lcd_rw, lcd_data, lcd_execute} !== 11'h000) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", {lcd_rs, lcd_rw, lcd_data, lcd_execute}, 11'h000);
      end
      checks++;
      if ({init_done, busy} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL reset_status: got %b expected %b", {init_done, busy}, 2'b01);
      end
   endtask

   task automatic test_init;
      int cyc;
      bit ok;
      txq.delete();
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (lcd_execute === 1'b1) begin
            cyc = i;
            break;
         end
      end
      checks++;
      if (cyc != P + 1) begin
         failures++;
         $display("[TB] FAIL first_cmd_cycle: got %0d expected %0d", cyc, P + 1);
      end
      wait_txns(3, 200, ok);
      checks++;
      if (init_done !== 1'b0 || !ok) begin
         failures++;
         $display("[TB] FAIL init_done_early: got %b expected 0 (ok=%0d)", init_done, ok);
      end
      wait_txns(38, 2000, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL init_txn_count: got %0d expected 38", txq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (txq[i] !== init_exp[i]) begin
            failures++;
            $display("[TB] FAIL init_byte[%0d]: got %h expected %h", i, txq[i], init_exp[i]);
         end
      end
      for (int k = 0; k < 34; k++) begin
         checks++;
         if (txq[4+k] !== repaint_byte(k)) begin
            failures++;
            $display("[TB] FAIL init_repaint[%0d]: got %h expected %h", k, txq[4+k], repaint_byte(k));
         end
      end
      wait_idle(200, ok);
      checks++;
      if (!ok || init_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL init_idle: got busy=%b init_done=%b expected busy=0 init_done=1", busy, init_done);
      end
   endtask

   task automatic test_single_write;
      bit ok;
      txq.delete();
      write_byte(5'd17, 8'h41);
      wait_txns(34, 2000, ok);
      wait_idle(200, ok);
      repeat (50) @(negedge clk);
      checks++;
      if (txq.size() != 34 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_write_count: got %0d busy=%b expected 34 busy=0", txq.size(), busy);
      end
      for (int k = 17; k < 20; k++) begin
         checks++;
         if (txq[k] !== repaint_byte(k)) begin
            failures++;
            $display("[TB] FAIL single_write[%0d]: got %h expected %h", k, txq[k], repaint_byte(k));
         end
      end
      checks++;
      if (txq[19] !== 9'h141) begin
         failures++;
         $display("[TB] FAIL single_write_char: got %h expected %h", txq[19], 9'h141);
      end
   endtask

   task automatic test_write_during_repaint;
      bit ok;
      txq.delete();
      write_byte(5'd0, 8'h20);
      wait_txns(12, 1000, ok);
      write_byte(5'd3, 8'h5A);
      wait_txns(68, 3000, ok);
      wait_idle(200, ok);
      repeat (50) @(negedge clk);
      checks++;
      if (txq.size() != 68 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wdr_count: got %0d busy=%b expected 68 busy=0", txq.size(), busy);
      end
      checks++;
      if (txq[4] !== 9'h120) begin
         failures++;
         $display("[TB] FAIL wdr_first_buf3: got %h expected %h", txq[4], 9'h120);
      end
      for (int k = 0; k < 34; k++) begin
         checks++;
         if (txq[34+k] !== repaint_byte(k)) begin
            failures++;
            $display("[TB] FAIL wdr_second[%0d]: got %h expected %h", k, txq[34+k], repaint_byte(k));
         end
      end
   endtask

   task automatic test_same_cycle;
      bit ok;
      txq.delete();
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = 5'd5;
      wr_data = 8'h31;
      model_buf[5] = 8'h31;
      @(negedge clk);
      wr_addr = 5'd6;
      wr_data = 8'h32;
      model_buf[6] = 8'h32;
      @(negedge clk);
      wr_en = 1'b0;
      wait_txns(68, 3000, ok);
      wait_idle(200, ok);
      repeat (50) @(negedge clk);
      checks++;
      if (txq.size() != 68 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL same_cycle_count: got %0d busy=%b expected 68 busy=0", txq.size(), busy);
      end
      for (int k = 0; k < 34; k += 33) begin
         checks++;
         if (txq[34+k] !== repaint_byte(k)) begin
            failures++;
            $display("[TB] FAIL same_cycle_second[%0d]: got %h expected %h", k, txq[34+k], repaint_byte(k));
         end
      end
      checks++;
      if (txq[40] !== 9'h131 || txq[41] !== 9'h132) begin
         failures++;
         $display("[TB] FAIL same_cycle_chars: got %h %h expected 131 132", txq[40], txq[41]);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      txq.delete();
      write_byte(5'd20, 8'h55);
      wait_txns(20, 1000, ok);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({lcd_rs, lcd_rw, lcd_data, lcd_execute, init_done, busy} !== 13'h001) begin
         failures++;
         $display("[TB] FAIL reset_mid_outputs: got %h expected %h",
                  {lcd_rs, lcd_rw, lcd_data, lcd_execute, init_done, busy}, 13'h001);
      end
      for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
      txq.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wait_txns(38, 2000, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL reset_mid_count: got %0d expected 38", txq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (txq[i] !== init_exp[i]) begin
            failures++;
            $display("[TB] FAIL reset_mid_init[%0d]: got %h expected %h", i, txq[i], init_exp[i]);
         end
      end
      for (int k = 0; k < 34; k++) begin
         checks++;
         if (txq[4+k] !== repaint_byte(k)) begin
            failures++;
            $display("[TB] FAIL reset_mid_repaint[%0d]: got %h expected %h", k, txq[4+k], repaint_byte(k));
         end
      end
      wait_idle(200, ok);
      checks++;
      if (!ok || init_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_mid_idle: got busy=%b init_done=%b expected 0 1", busy, init_done);
      end
   endtask

   task automatic test_handshake;
      int seen;
      bit ok;
      model_en = 1'b0;
      manual_rdy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      txq.delete();
      rst = 1'b1;
      seen = 0;
      repeat (P + 50) begin
         @(posedge clk);
         #1;
         if (lcd_execute !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("[TB] FAIL hs_no_exec: got %0d pulses expected 0", seen);
      end
      @(negedge clk);
      manual_rdy = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (lcd_execute !== 1'b1 || {lcd_rs, lcd_data} !== 9'h038) begin
         failures++;
         $display("[TB] FAIL hs_pulse: got exec=%b byte=%h expected 1 038", lcd_execute, {lcd_rs, lcd_data});
      end
      manual_rdy = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (lcd_execute !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0 || {lcd_rs, lcd_data} !== 9'h038) begin
         failures++;
         $display("[TB] FAIL hs_hold: got %0d extra pulses byte=%h expected 0 038", seen, {lcd_rs, lcd_data});
      end
      @(negedge clk);
      manual_rdy = 1'b1;
      wait_txns(2, 20, ok);
      checks++;
      if (!ok || txq[0] !== 9'h038 || txq[1] !== 9'h00C) begin
         failures++;
         $display("[TB] FAIL hs_next: got %h %h expected 038 00C", txq[0], txq[1]);
      end
      model_en = 1'b1;
      wait_txns(38, 2000, ok);
      wait_idle(200, ok);
      checks++;
      if (!ok || txq.size() != 38) begin
         failures++;
         $display("[TB] FAIL hs_finish: got %0d txns busy=%b expected 38 busy=0", txq.size(), busy);
      end
      checks++;
      if (exec_double != 0 || unstable != 0) begin
         failures++;
         $display("[TB] FAIL exec_protocol: got double=%0d unstable=%0d expected 0 0", exec_double, unstable);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
      test_reset;
      test_init;
      test_single_write;
      test_write_during_repaint;
      test_same_cycle;
      test_reset_mid;
      test_handshake;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
